egd_encoder: RTL and testbench

EGD_ENCODER -- requirements
Module: egd_encoder

---
 rtl/egd_pkg.sv | 30 +++
 rtl/egd_bit_packer.sv | 85 ++++++++
 rtl/egd_encoder.sv | 114 +++++++++++
 tb/tb_egd_encoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/egd_pkg.sv
// rtl/egd_pkg.sv - shared Exp-Golomb definitions for the encoder and decoder
//   Contents: FSM state enum, word width, longest prefix length (MAX_M),
//   longest codeword length, codeNum+1 width, and a floor(log2) helper.
package egd_pkg;

  localparam int WORD_W     = 16;
  localparam int MAX_M      = 16;
  localparam int MAX_CW_LEN = 2 * MAX_M + 1;
  localparam int CODE_W     = 17;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    SUFFIX = 2'd2,
    FLUSH  = 2'd3
  } egd_state_t;

  // Index of the highest set bit. The encoder only calls this with a
  // non-zero argument (codeNum+1 >= 1).
  function automatic logic [CNT_W-1:0] floor_log2(input logic [CODE_W-1:0] x);
    logic [CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (x[i]) r = CNT_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/egd_bit_packer.sv
// rtl/egd_bit_packer.sv - MSB-first bit accumulator with one-word output register
//   clk, reset_n          : clock, asynchronous active-low reset
//   bit_valid/bit_data    : one bit offered per cycle
//   bit_ready             : bit accepted this cycle (low while a full word is stuck)
//   pad                   : zero-pad the partial word and mark it last
//   fill                  : number of bits held in the accumulator (0..WORD_W)
//   last_xfer             : the padded (last) word moves to the output this cycle
//   out_valid/out_ready   : output word handshake
//   out_data, out_last    : output word, flush marker
module egd_bit_packer #(
  parameter int WORD_W = 16,
  parameter int FILL_W = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bit_valid,
  input  logic              bit_data,
  output logic              bit_ready,
  input  logic              pad,
  output logic [FILL_W-1:0] fill,
  output logic              last_xfer,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  localparam int IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0] acc, acc_nxt, base_acc;
  logic [FILL_W-1:0] fill_nxt, base_fill;
  logic [IDX_W-1:0]  idx;
  logic              last_pend, last_pend_nxt;
  logic              full, out_free, xfer, take;

  assign full      = (fill == FILL_W'(WORD_W));
  assign out_free  = !out_valid || out_ready;
  assign xfer      = full && out_free;
  // A full accumulator that drains this cycle can still take a bit into
  // its freshly emptied MSB, so emission never loses a cycle to a transfer.
  assign bit_ready = !full || out_free;
  assign take      = bit_valid && bit_ready;
  assign last_xfer = xfer && (last_pend || pad);

  always_comb begin
    base_acc      = xfer ? '0 : acc;
    base_fill     = xfer ? '0 : fill;
    acc_nxt       = base_acc;
    fill_nxt      = base_fill;
    last_pend_nxt = xfer ? 1'b0 : last_pend;
    idx           = IDX_W'(WORD_W - 1) - base_fill[IDX_W-1:0];
    if (take) begin
      acc_nxt[idx] = bit_data;
      fill_nxt     = base_fill + FILL_W'(1);
    end else if (pad && !xfer && (fill != '0)) begin
      // Unused low bits are already zero, so padding only declares the word full.
      fill_nxt      = FILL_W'(WORD_W);
      last_pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      fill      <= '0;
      last_pend <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      fill      <= fill_nxt;
      last_pend <= last_pend_nxt;
      if (xfer) begin
        out_data  <= acc;
        out_valid <= 1'b1;
        out_last  <= last_pend || pad;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/egd_encoder.sv
// rtl/egd_encoder.sv - ue(v)/se(v) Exp-Golomb encoder producing packed words
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid/in_ready    : element handshake
//   in_value, in_signed  : element value, 1 = se(v) mapping
//   flush                : pad the partial word and emit it with out_last
//   out_valid/out_ready  : output word handshake
//   out_data, out_last   : packed word (earliest bit in MSB), flush marker
//   busy                 : element or flush in progress, or bits held
module egd_encoder #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_value,
  input  logic              in_signed,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  import egd_pkg::*;

  egd_state_t        state, state_nxt;
  logic [CODE_W-1:0] code_num, code_p1, mag, code_r;
  logic [CNT_W-1:0]  m_in, m_r, cnt;
  logic [CNT_W-1:0]  fill;
  logic              accept, bit_valid, bit_data, bit_ready, pad, last_xfer;

  // se(v): k>0 -> 2k-1, k<=0 -> -2k. The 17-bit negate covers k = -32768.
  always_comb begin
    mag = '0 - {in_value[15], in_value};
    if (!in_signed)
      code_num = {1'b0, in_value};
    else if (!in_value[15] && (in_value != '0))
      code_num = {in_value, 1'b0} - CODE_W'(1);
    else
      code_num = {mag[15:0], 1'b0};
    code_p1 = code_num + CODE_W'(1);
    m_in    = floor_log2(code_p1);
  end

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; PREFIX/SUFFIX only advance when the packer takes the bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (flush && (fill != '0)) state_nxt = FLUSH;
        else if (accept)           state_nxt = (m_in != '0) ? PREFIX : SUFFIX;
      end
      PREFIX: if (bit_ready && (cnt == CNT_W'(1))) state_nxt = SUFFIX;
      SUFFIX: if (bit_ready && (cnt == '0))        state_nxt = IDLE;
      FLUSH:  if (last_xfer)                       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt counts remaining prefix zeros in PREFIX, then indexes the suffix bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_r <= '0;
      m_r    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      code_r <= code_p1;
      m_r    <= m_in;
      cnt    <= m_in;
    end else if ((state == PREFIX) && bit_ready) begin
      cnt <= (cnt == CNT_W'(1)) ? m_r : cnt - CNT_W'(1);
    end else if ((state == SUFFIX) && bit_ready && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Outputs; flush in IDLE takes priority over a new element.
  always_comb begin
    in_ready  = (state == IDLE) && !flush;
    bit_valid = (state == PREFIX) || (state == SUFFIX);
    bit_data  = (state == SUFFIX) ? code_r[cnt] : 1'b0;
    pad       = (state == FLUSH);
    busy      = !((state == IDLE) && (fill == '0));
  end

  egd_bit_packer #(
    .WORD_W (WORD_W),
    .FILL_W (CNT_W)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .bit_ready (bit_ready),
    .pad       (pad),
    .fill      (fill),
    .last_xfer (last_xfer),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_egd_encoder.sv
// tb/tb_egd_encoder.sv - directed self-checking bench for egd_encoder
module tb_egd_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = '0;
  logic        in_signed = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] words[$];

  egd_encoder #(.WORD_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_signed (in_signed),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) words.push_back({out_last, out_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input int idx, input logic last, input logic [15:0] data);
    logic [31:0] obs;
    if (idx < words.size()) obs = 32'(words[idx]);
    else                    obs = 32'hDEAD_BEEF;
    check(tag, obs, 32'({last, data}));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input logic s);
    int t;
    t = 0;
    in_value = v;
    in_signed = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_flush();
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("flush_wait_idle", 32'(in_ready), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (words.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("wait_words", 32'(words.size() >= n), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    cycles(1);

    // ue 0 x16 -> 0xFFFF
    for (int i = 0; i < 16; i++) send(16'd0, 1'b0);
    wait_words(1);
    cycles(3);
    check("ue0_count", 32'(words.size()), 32'd1);
    check_word("ue0_word", 0, 1'b0, 16'hFFFF);
    check("ue0_busy", 32'(busy), 32'd0);
    words.delete();

    // ue 3, se -2, flush -> 00100 00101 + pad = 0x2140 last
    send(16'd3, 1'b0);
    send(16'hFFFE, 1'b1);
    check("mix_busy", 32'(busy), 32'd1);
    idle_flush();
    wait_words(1);
    cycles(3);
    check("mix_count", 32'(words.size()), 32'd1);
    check_word("mix_word", 0, 1'b1, 16'h2140);
    check("mix_busy_after", 32'(busy), 32'd0);
    words.delete();

    // ue 65535 (33 bits), flush -> 0x0000, 0x8000, 0x0000 last
    send(16'hFFFF, 1'b0);
    idle_flush();
    wait_words(3);
    cycles(3);
    check("max_count", 32'(words.size()), 32'd3);
    check_word("max_w0", 0, 1'b0, 16'h0000);
    check_word("max_w1", 1, 1'b0, 16'h8000);
    check_word("max_w2", 2, 1'b1, 16'h0000);
    words.delete();

    // Backpressure: word 0xFFFF pending, second word 0x27FF full, ue 1 stalls
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(16'd0, 1'b0);
    send(16'd3, 1'b0);
    for (int i = 0; i < 11; i++) send(16'd0, 1'b0);
    send(16'd1, 1'b0);
    cycles(2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'hFFFF);
    end
    check("stall_no_words", 32'(words.size()), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle_flush();
    wait_words(3);
    cycles(3);
    check("stall_count", 32'(words.size()), 32'd3);
    check_word("stall_w0", 0, 1'b0, 16'hFFFF);
    check_word("stall_w1", 1, 1'b0, 16'h27FF);
    check_word("stall_w2", 2, 1'b1, 16'h4000);
    words.delete();

    // Reset during PREFIX of ue 65535 with a word pending
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(16'd0, 1'b0);
    cycles(3);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    send(16'hFFFF, 1'b0);
    cycles(4);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    #1;
    reset_n = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    cycles(1);
    for (int i = 0; i < 16; i++) send(16'd0, 1'b0);
    wait_words(1);
    cycles(3);
    check("postrst_count", 32'(words.size()), 32'd1);
    check_word("postrst_word", 0, 1'b0, 16'hFFFF);

    // Flush with nothing held -> no word
    idle_flush();
    cycles(5);
    check("flush_empty_count", 32'(words.size()), 32'd1);
    check("flush_empty_in_ready", 32'(in_ready), 32'd1);
    check("flush_empty_busy", 32'(busy), 32'd0);
    words.delete();

    // Flush during SUFFIX of ue 65535 is ignored
    send(16'hFFFF, 1'b0);
    cycles(20);
    check("sfx_busy", 32'(busy), 32'd1);
    check("sfx_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 15; i++) send(16'd0, 1'b0);
    wait_words(3);
    cycles(3);
    check("sfx_count", 32'(words.size()), 32'd3);
    check_word("sfx_w0", 0, 1'b0, 16'h0000);
    check_word("sfx_w1", 1, 1'b0, 16'h8000);
    check_word("sfx_w2", 2, 1'b0, 16'h7FFF);
    check("sfx_busy_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
